// File: rtl/uart_buffered_cfg.sv
// Buffered UART with a configurable character format, TX/RX FIFOs and per-word RX error flags.
// Define UART_LOOPBACK_EN to build the internal TX->RX loopback mux driven by the loopback port.

module ft_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  // A push at full is accepted only when a pop frees the head in the same cycle.
  always_comb begin
    full    = (cnt_q == (AW+1)'(DEPTH));
    empty   = (cnt_q == '0);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop_ok  ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
    dout    = empty ? '0 : mem[rd_q];
    level   = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module uart_buffered_cfg #(
  parameter int FCLK      = 100000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH  = 32,
  parameter int RX_DEPTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_en,
  output logic                        tx_full,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic                        tx_busy,
  input  logic                        rx_next,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_err_frame,
  output logic                        rx_err_parity,
  output logic                        rx_empty,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic                        rx_overrun,
  input  logic                        err_clr,
  input  logic                        loopback,
  input  logic                        rx,
  output logic                        tx
);
  localparam int DIV = (FCLK + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int RW  = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_e;

  // ---------------- TX ----------------
  state_e               tx_st_q, tx_st_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, tx_head;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_pop, tx_load, tx_empty, tx_tick;

  ft_fifo #(.W(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_en),
    .pop   (tx_pop),
    .din   (tx_data),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  assign tx_tick = (tx_cnt_q == CW'(DIV - 1));
  assign tx_busy = (tx_st_q != S_IDLE) || !tx_empty;

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_tick ? '0 : tx_cnt_q + 1'b1;
    tx_idx_d  = tx_idx_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_line_d = tx_line_q;
    tx_load   = 1'b0;
    tx_pop    = 1'b0;
    case (tx_st_q)
      S_IDLE: begin
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
        tx_load   = !tx_empty;
      end
      S_START: if (tx_tick) begin
        tx_line_d = tx_sh_q[0];
        tx_idx_d  = '0;
        tx_st_d   = S_DATA;
      end
      S_DATA: if (tx_tick) begin
        tx_sh_d = tx_sh_q >> 1;
        if (tx_idx_q == 4'(DATA_BITS - 1)) begin
          tx_idx_d = '0;
          if (PARITY != 0) begin
            tx_line_d = tx_par_q;
            tx_st_d   = S_PAR;
          end else begin
            tx_line_d = 1'b1;
            tx_st_d   = S_STOP;
          end
        end else begin
          tx_line_d = tx_sh_q[1];
          tx_idx_d  = tx_idx_q + 1'b1;
        end
      end
      S_PAR: if (tx_tick) begin
        tx_line_d = 1'b1;
        tx_idx_d  = '0;
        tx_st_d   = S_STOP;
      end
      S_STOP: if (tx_tick) begin
        if (tx_idx_q == 4'(STOP_BITS - 1)) begin
          tx_st_d = S_IDLE;
          tx_load = !tx_empty;
        end else begin
          tx_idx_d = tx_idx_q + 1'b1;
        end
      end
      default: tx_st_d = S_IDLE;
    endcase
    // Loading from IDLE or straight out of STOP keeps frames back-to-back.
    if (tx_load) begin
      tx_pop    = 1'b1;
      tx_sh_d   = tx_head;
      tx_par_d  = (^tx_head) ^ (PARITY == 1);
      tx_line_d = 1'b0;
      tx_cnt_d  = '0;
      tx_st_d   = S_START;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q   <= S_IDLE;
      tx_cnt_q  <= '0;
      tx_idx_q  <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_line_q <= 1'b1;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_idx_q  <= tx_idx_d;
      tx_sh_q   <= tx_sh_d;
      tx_par_q  <= tx_par_d;
      tx_line_q <= tx_line_d;
    end
  end

  // ---------------- pin / loopback ----------------
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  logic tx_pin_q, tx_pin_d;
  assign rx_src   = loopback ? tx_line_q : rx;
  assign tx_pin_d = loopback ? 1'b1 : tx_line_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_pin_q <= 1'b1;
    else        tx_pin_q <= tx_pin_d;
  end
  assign tx = tx_pin_q;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign rx_src          = rx;
  assign tx              = tx_line_q;
`endif

  // ---------------- RX ----------------
  state_e               rx_st_q, rx_st_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 rx_tick, rx_half, rx_push, rx_perr, rx_full;
  logic [RW-1:0]        rx_word;
  logic                 ovr_q, ovr_d;

  assign rx_tick = (rx_cnt_q == CW'(DIV - 1));
  assign rx_half = (rx_cnt_q == CW'(DIV / 2 - 1));
  assign rx_perr = (PARITY == 0) ? 1'b0 : ((^rx_sh_q) ^ rx_par_q ^ (PARITY == 1));
  assign rx_word = {~rx_sync_q, rx_perr, rx_sh_q};

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
    rx_idx_d = rx_idx_q;
    rx_sh_d  = rx_sh_q;
    rx_par_d = rx_par_q;
    rx_push  = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_st_d = S_START;
      end
      // Start bit is re-checked at its centre so a short glitch is discarded.
      S_START: if (rx_half) begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        rx_st_d  = rx_sync_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_tick) begin
        rx_sh_d = {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
        if (rx_idx_q == 4'(DATA_BITS - 1)) rx_st_d = (PARITY != 0) ? S_PAR : S_STOP;
        else                               rx_idx_d = rx_idx_q + 1'b1;
      end
      S_PAR: if (rx_tick) begin
        rx_par_d = rx_sync_q;
        rx_st_d  = S_STOP;
      end
      S_STOP: if (rx_tick) begin
        rx_push = 1'b1;
        rx_st_d = rx_sync_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_st_d = S_IDLE;
      end
      default: rx_st_d = S_IDLE;
    endcase
    ovr_d = ovr_q;
    if (err_clr)                          ovr_d = 1'b0;
    if (rx_push && rx_full && !rx_next)   ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= '0;
      rx_idx_q  <= '0;
      rx_sh_q   <= '0;
      rx_par_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_src;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_idx_q  <= rx_idx_d;
      rx_sh_q   <= rx_sh_d;
      rx_par_q  <= rx_par_d;
      ovr_q     <= ovr_d;
    end
  end

  ft_fifo #(.W(RW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_next),
    .din   (rx_word),
    .dout  ({rx_err_frame, rx_err_parity, rx_data}),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  assign rx_overrun = ovr_q;
endmodule

// File: tb/tb_uart_buffered_cfg.sv
// Randomized self-checking bench for uart_buffered_cfg using a frame-level reference model.
module tb_uart_buffered_cfg;
  localparam int FCLK = 1600000;
  localparam int BAUD = 100000;
  localparam int DB   = 8;
  localparam int PAR  = 1;
  localparam int SB   = 2;
  localparam int TXD  = 4;
  localparam int RXD  = 4;
  localparam int DIV  = (FCLK + BAUD / 2) / BAUD;
  localparam int NB   = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [DB-1:0]          tx_data = '0;
  logic                   tx_en = 1'b0;
  logic                   tx_full, tx_busy;
  logic [$clog2(TXD):0]   tx_level;
  logic                   rx_next = 1'b0;
  logic [DB-1:0]          rx_data;
  logic                   rx_err_frame, rx_err_parity, rx_empty, rx_overrun;
  logic [$clog2(RXD):0]   rx_level;
  logic                   err_clr = 1'b0;
  logic                   loopback = 1'b0;
  logic                   rx, tx;
  logic                   ext_loop = 1'b0;
  logic                   rx_drv = 1'b1;
  int                     cyc = 0;
  int                     n_chk = 0;
  int                     n_err = 0;
  logic [DB+1:0]          exp_q[$];

  assign rx = ext_loop ? tx : rx_drv;

  uart_buffered_cfg #(
    .FCLK(FCLK), .BAUD(BAUD), .DATA_BITS(DB), .PARITY(PAR),
    .STOP_BITS(SB), .TX_DEPTH(TXD), .RX_DEPTH(RXD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_en(tx_en), .tx_full(tx_full),
    .tx_level(tx_level), .tx_busy(tx_busy), .rx_next(rx_next), .rx_data(rx_data),
    .rx_err_frame(rx_err_frame), .rx_err_parity(rx_err_parity), .rx_empty(rx_empty),
    .rx_level(rx_level), .rx_overrun(rx_overrun), .err_clr(err_clr),
    .loopback(loopback), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Parity bit a correct transmitter appends.
  function automatic logic par_bit(input logic [DB-1:0] d);
    int ones = $countones(d);
    if (PAR == 1) return logic'((ones % 2) == 0);
    return logic'((ones % 2) == 1);
  endfunction

  // Line level during bit period k of a correct frame carrying d.
  function automatic logic frame_bit(input logic [DB-1:0] d, input int k);
    if (k == 0)                      return 1'b0;
    if (k <= DB)                     return d[k-1];
    if (PAR != 0 && k == DB + 1)     return par_bit(d);
    return 1'b1;
  endfunction

  function automatic logic [DB+1:0] exp_rx(input logic [DB-1:0] d, input logic pbit, input logic stop);
    logic pe;
    pe = (PAR != 0) && (pbit != par_bit(d));
    return {~stop, pe, d};
  endfunction

  task automatic push_tx(input logic [DB-1:0] d);
    @(negedge clk); tx_data = d; tx_en = 1'b1;
    @(negedge clk); tx_en = 1'b0;
  endtask

  task automatic check_tx_frame(input logic [DB-1:0] d);
    int n = 0;
    push_tx(d);
    while (tx !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
    chk("tx_start_latency", 32'(n), 32'd1);
    chk("tx_level_after_pop", 32'(tx_level), 32'd0);
    for (int k = 0; k < NB; k++) begin
      repeat ((k == 0) ? DIV / 2 : DIV) @(posedge clk);
      #1;
      chk("tx_bit", {23'd0, 4'(k), 4'd0, tx}, {23'd0, 4'(k), 4'd0, frame_bit(d, k)});
    end
    repeat (DIV / 2 - 1) @(posedge clk);
    #1 chk("tx_busy_last_clk", 32'(tx_busy), 32'd1);
    @(posedge clk);
    #1 chk("tx_busy_after_stop", 32'(tx_busy), 32'd0);
  endtask

  task automatic wait_busy_low(input int budget);
    int n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin @(posedge clk); #1; n++; end
    if (n >= budget) chk("tx_busy_timeout", 32'(tx_busy), 32'd0);
  endtask

  task automatic send_rx(input logic [DB-1:0] d, input logic pbit, input logic stop);
    logic b;
    @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      b = frame_bit(d, k);
      if (PAR != 0 && k == DB + 1) b = pbit;
      if (k == NB - SB)            b = stop;
      rx_drv = b;
      repeat (DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic pop_all();
    logic [DB+1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      chk("rx_empty_before_pop", 32'(rx_empty), 32'd0);
      chk("rx_word", 32'({rx_err_frame, rx_err_parity, rx_data}), 32'(e));
      rx_next = 1'b1;
      @(negedge clk);
      rx_next = 1'b0;
    end
    @(negedge clk);
    chk("rx_empty_after_pops", 32'(rx_empty), 32'd1);
    chk("rx_level_after_pops", 32'(rx_level), 32'd0);
  endtask

  initial begin
    logic [DB-1:0] w;
    logic [DB-1:0] words[3];
    int c0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_tx_full", 32'(tx_full), 32'd0);
    chk("rst_tx_level", 32'(tx_level), 32'd0);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);
    chk("rst_rx_level", 32'(rx_level), 32'd0);
    chk("rst_rx_overrun", 32'(rx_overrun), 32'd0);
    chk("rst_rx_word", 32'({rx_err_frame, rx_err_parity, rx_data}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // single TX frames
    check_tx_frame(8'hA5);
    for (int i = 0; i < 2; i++) check_tx_frame(DB'($urandom));

    // TX FIFO full: TXD+2 back-to-back pushes, last one must be dropped
    @(negedge clk); tx_en = 1'b1; tx_data = DB'($urandom);
    @(negedge clk); c0 = cyc;
    for (int i = 1; i < TXD + 2; i++) begin tx_data = DB'($urandom); @(negedge clk); end
    tx_en = 1'b0;
    chk("tx_full_at_depth", 32'(tx_full), 32'd1);
    chk("tx_level_at_depth", 32'(tx_level), 32'(TXD));
    wait_busy_low((TXD + 2) * NB * DIV);
    chk("tx_full_burst_duration", 32'(cyc - c0), 32'(1 + (TXD + 1) * NB * DIV));

    // external loopback, back-to-back frames
    ext_loop = 1'b1;
    words[0] = '0; words[1] = '1; words[2] = DB'($urandom);
    @(negedge clk); tx_en = 1'b1; tx_data = words[0];
    @(negedge clk); c0 = cyc; tx_data = words[1];
    @(negedge clk); tx_data = words[2];
    @(negedge clk); tx_en = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back({2'b00, words[i]});
    wait_busy_low(4 * NB * DIV);
    chk("loop_no_idle_gap", 32'(cyc - c0), 32'(1 + 3 * NB * DIV));
    repeat (4) @(posedge clk);
    #1 chk("loop_rx_level", 32'(rx_level), 32'd3);
    ext_loop = 1'b0;
    pop_all();

    // injected frames: good, bad parity, bad stop
    w = DB'($urandom); send_rx(w, par_bit(w), 1'b1);  exp_q.push_back(exp_rx(w, par_bit(w), 1'b1));
    w = DB'($urandom); send_rx(w, ~par_bit(w), 1'b1); exp_q.push_back(exp_rx(w, ~par_bit(w), 1'b1));
    w = DB'($urandom); send_rx(w, par_bit(w), 1'b0);  exp_q.push_back(exp_rx(w, par_bit(w), 1'b0));
    w = 8'h41;         send_rx(w, ~par_bit(w), 1'b1); exp_q.push_back(exp_rx(w, ~par_bit(w), 1'b1));
    repeat (DIV) @(negedge clk);
    chk("inject_rx_level", 32'(rx_level), 32'd4);
    pop_all();

    // false start: short low glitch stores nothing
    @(negedge clk); rx_drv = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (NB * DIV) @(negedge clk);
    chk("false_start_rx_empty", 32'(rx_empty), 32'd1);

    // line break for 20 bit times: exactly one framing-error word
    @(negedge clk); rx_drv = 1'b0;
    repeat (20 * DIV) @(negedge clk);
    chk("break_rx_level", 32'(rx_level), 32'd1);
    rx_drv = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    chk("break_rx_level_after_release", 32'(rx_level), 32'd1);
    exp_q.push_back(exp_rx('0, 1'b0, 1'b0));
    pop_all();

    // overrun: RXD+1 words without popping
    for (int i = 0; i < RXD + 1; i++) begin
      w = DB'($urandom);
      send_rx(w, par_bit(w), 1'b1);
      if (i < RXD) exp_q.push_back(exp_rx(w, par_bit(w), 1'b1));
    end
    repeat (DIV) @(negedge clk);
    chk("ovr_rx_level", 32'(rx_level), 32'(RXD));
    chk("ovr_flag_set", 32'(rx_overrun), 32'd1);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("ovr_flag_cleared", 32'(rx_overrun), 32'd0);
    pop_all();

    // asynchronous reset in the middle of a TX start bit, with an RX word pending
    w = DB'($urandom); send_rx(w, par_bit(w), 1'b1);
    repeat (DIV) @(negedge clk);
    push_tx(DB'($urandom));
    repeat (DIV / 2) @(negedge clk);
    chk("pre_reset_tx_low", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_tx_busy", 32'(tx_busy), 32'd0);
    chk("midrst_tx_level", 32'(tx_level), 32'd0);
    chk("midrst_rx_level", 32'(rx_level), 32'd0);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    check_tx_frame(DB'($urandom));

`ifdef UART_LOOPBACK_EN
    begin
      int hi_viol = 0;
      loopback = 1'b1;
      @(negedge clk);
      push_tx(8'h5A);
      for (int i = 0; i < (NB + 1) * DIV; i++) begin
        @(negedge clk);
        if (tx !== 1'b1) hi_viol++;
      end
      chk("lb_tx_pin_high", 32'(hi_viol), 32'd0);
      chk("lb_rx_level", 32'(rx_level), 32'd1);
      exp_q.push_back({2'b00, 8'h5A});
      pop_all();
      loopback = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_buffered_cfg.md
Name: uart_buffered_cfg

Overview:
Configurable buffered UART; successor to the fixed 8N1 buffered UART.
- Character format is parametrised: data width, parity mode, stop bits. Independent TX/RX FIFO depths.
- Adds per-word RX error flags, a sticky overrun flag, FIFO fill levels and a TX busy indicator.
- Sits between a CPU/streaming front end and the board-level rx/tx pins. Contains its own TX/RX bit engines and two ft_fifo instances, width-extended for the RX flags.

Parameters:
- FCLK, 100000000, clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. DIV = (FCLK + BAUD/2) / BAUD clocks per bit; DIV must be >= 16.
- DATA_BITS, 8, data bits per character, legal 5..9, sent LSB first.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, legal 1 or 2.
- TX_DEPTH, 32, TX FIFO depth, power of 2, >= 2.
- RX_DEPTH, 32, RX FIFO depth, power of 2, >= 2.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- tx_data, in, DATA_BITS, word to transmit.
- tx_en, in, 1, push tx_data into TX FIFO.
- tx_full, out, 1, TX FIFO full.
- tx_level, out, $clog2(TX_DEPTH)+1, TX FIFO occupancy.
- tx_busy, out, 1, TX engine mid-character or TX FIFO non-empty.
- rx_next, in, 1, pop head of RX FIFO.
- rx_data, out, DATA_BITS, head word (first-word-fall-through).
- rx_err_frame, out, 1, head word had stop bit = 0.
- rx_err_parity, out, 1, head word failed parity (always 0 when PARITY = 0).
- rx_empty, out, 1, RX FIFO empty.
- rx_level, out, $clog2(RX_DEPTH)+1, RX FIFO occupancy.
- rx_overrun, out, 1, sticky: a word was dropped because the RX FIFO was full.
- err_clr, in, 1, clears rx_overrun.
- loopback, in, 1, internal loopback request (see Optional Feature).
- rx, in, 1, serial input, asynchronous to clk.
- tx, out, 1, serial output, idle high.

Behaviour:

Reset (asynchronous, immediate, also mid-frame):
- tx = 1, tx_busy = 0, both FIFOs empty: tx_full = 0, rx_empty = 1, levels = 0.
- rx_overrun = 0; rx_data, rx_err_frame, rx_err_parity = 0.
- Both FSMs return to IDLE; the baud counter is cleared.

FIFO rules (both FIFOs):
- Push when full is ignored; pop when empty is ignored.
- Push and pop in the same cycle:
  - At full, both succeed and the level is unchanged.
  - At empty, the push succeeds and the pop is ignored.
- Levels update on the clock edge after the push/pop.

TX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- PARITY is skipped when PARITY = 0.
- IDLE: if the TX FIFO is non-empty, pop it, latch the word, go to START. tx goes low 2 clk after tx_en into an empty FIFO with the engine idle.
- Each state lasts DIV clk.
  - DATA: DATA_BITS bit periods, LSB first.
  - PARITY: odd mode makes total ones (data + parity) odd; even mode makes it even.
  - STOP: STOP_BITS x DIV clk at tx = 1.
- Back-to-back: when STOP ends and the FIFO is non-empty, go directly to START with no extra idle bit.
- tx is registered; no glitches.

RX path:
- rx passes through a 2-flop synchronizer; idle level is 1.

RX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> (WAIT_HIGH) -> IDLE.
- IDLE: a falling edge on the synchronized rx goes to START.
- START: sample at DIV/2. If the sample is 1, it is a false start: return to IDLE and store nothing.
- Subsequent samples are taken every DIV clk, at bit centre.
- Only the first stop bit is checked; a second stop bit is not required on RX.
- At the STOP sample, build {frame_err, parity_err, data}:
  - If the RX FIFO is not full, push it (rx_empty deasserts on the next edge).
  - If the RX FIFO is full, drop the word and set rx_overrun.
- On frame error (stop = 0, e.g. a line break), enter WAIT_HIGH and stay there until rx = 1 before returning to IDLE.

Overrun flag:
- rx_overrun is cleared by err_clr.
- If err_clr and a new overrun occur in the same cycle, set wins.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined:
  - While loopback = 1, the RX engine input is the internal TX serial signal (before the tx pin), and the tx pin is held at 1.
  - Switching loopback mid-frame is allowed; the frame in progress may be corrupted or false-started, but the FSMs must recover to IDLE.
- Not defined: the loopback port is present but ignored, and no loopback mux is synthesized.

Test Plan:
1. Defaults (DIV = 868), push 0xA5 -> tx low for 868 clk, then bits 1,0,1,0,0,1,0,1, then high 868 clk; tx_busy high throughout, low after stop.
2. Loop tx to rx externally, push 0x00, 0xFF, 0x3C back-to-back -> rx_level reaches 3; pops return the same words in order with both error flags 0; no idle gap between TX frames.
3. DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x41 -> parity bit 0, two stop periods; inject an RX frame 0x41 with parity bit 1 -> rx_data = 0x41, rx_err_parity = 1.
4. Hold rx low for 20 bit times -> one word 0x00 with rx_err_frame = 1; no further words until rx returns high.
5. RX_DEPTH=4, receive 5 words without popping -> rx_level = 4, rx_overrun = 1, 5th word lost; err_clr -> rx_overrun = 0.
6. Assert rst_n low mid-TX-character -> tx = 1 immediately, levels = 0; the next push transmits a clean frame. With UART_LOOPBACK_EN defined and loopback = 1, push 0x5A -> rx receives 0x5A while the tx pin stays 1.
